// File: rtl/lsu_sram_axi.sv
// lsu_sram_axi: word-addressed data SRAM behind AXI4-Lite-style read and write slave ports.
// Build option: define SRAM_RAND_DELAY_EN for LFSR-driven random latency and ready throttling.
module lsu_sram_axi #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned LATENCY     = 1,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [7:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [1:0]  OKAY     = 2'b00;
    localparam logic [1:0]  SLVERR   = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

    logic [31:0] mem [DEPTH_WORDS];

    r_state_t          r_state;
    logic [31:0]       r_addr;
    logic [15:0]       r_cnt;
    w_state_t          w_state;
    logic [31:0]       w_addr;
    logic [31:0]       w_data;
    logic [3:0]        w_strb;
    logic              aw_got;
    logic              w_got;
    logic [15:0]       w_cnt;
    logic [15:0]       load_val;
    logic              throttle;

    logic [31:0]       r_off;
    logic [31:0]       w_off;
    logic              r_in;
    logic              w_in;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx;
    logic              w_commit;
    logic              unused_bits;

    assign r_off = r_addr - BASE_ADDR;
    assign w_off = w_addr - BASE_ADDR;
    assign r_in  = (r_addr >= BASE_ADDR) && ({1'b0, r_addr} < END_ADDR);
    assign w_in  = (w_addr >= BASE_ADDR) && ({1'b0, w_addr} < END_ADDR);
    assign r_idx = r_off[IDX_W+1:2];
    assign w_idx = w_off[IDX_W+1:2];
    assign unused_bits = ^{r_off[31:IDX_W+2], r_off[1:0], w_off[31:IDX_W+2], w_off[1:0], wstrb[7:4]};

`ifdef SRAM_RAND_DELAY_EN
    logic [7:0]  lfsr;
    logic [31:0] unused_cfg;

    assign unused_cfg = 32'(LATENCY);
    assign load_val   = {14'd0, lfsr[1:0]};
    assign throttle   = lfsr[7];

    // Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr <= LFSR_SEED;
        else      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
`else
    logic [7:0] unused_cfg;

    assign unused_cfg = LFSR_SEED;
    assign load_val   = 16'(LATENCY - 1);
    assign throttle   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= R_IDLE;
            arready <= 1'b1;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= '0;
            r_addr  <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        r_addr  <= araddr;
                        r_cnt   <= load_val;
                        arready <= 1'b0;
                        r_state <= R_WAIT;
                    end else begin
                        arready <= !throttle;
                    end
                end
                R_WAIT: begin
                    if (r_cnt == '0) begin
                        rdata   <= r_in ? mem[r_idx] : '0;
                        rresp   <= r_in ? OKAY : SLVERR;
                        rvalid  <= 1'b1;
                        r_state <= R_RESP;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        rvalid  <= 1'b0;
                        arready <= 1'b1;
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // AW and W are captured independently; the FSM leaves idle once both are held
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state <= W_IDLE;
            awready <= 1'b1;
            wready  <= 1'b1;
            bvalid  <= 1'b0;
            bresp   <= '0;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            w_addr  <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            w_cnt   <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (awvalid && awready) begin
                        w_addr  <= awaddr;
                        aw_got  <= 1'b1;
                        awready <= 1'b0;
                    end else if (!aw_got) begin
                        awready <= !throttle;
                    end
                    if (wvalid && wready) begin
                        w_data <= wdata;
                        w_strb <= wstrb[3:0];
                        w_got  <= 1'b1;
                        wready <= 1'b0;
                    end else if (!w_got) begin
                        wready <= !throttle;
                    end
                    if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready))) begin
                        w_cnt   <= load_val;
                        w_state <= W_WAIT;
                    end
                end
                W_WAIT: begin
                    if (w_cnt == '0) begin
                        bresp   <= w_in ? OKAY : SLVERR;
                        bvalid  <= 1'b1;
                        w_state <= W_RESP;
                    end else begin
                        w_cnt <= w_cnt - 16'd1;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        aw_got  <= 1'b0;
                        w_got   <= 1'b0;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    assign w_commit = (w_state == W_WAIT) && (w_cnt == '0) && w_in;

    // Storage is not reset; a same-edge read samples the pre-write word
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_strb[i]) mem[w_idx][8*i +: 8] <= w_data[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_lsu_sram_axi.sv
// Scoreboard bench for lsu_sram_axi: drivers queue expected R/B responses, monitors pop and compare.
module tb_lsu_sram_axi;
    localparam int LAT = 1;

    logic        clk;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [7:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    lsu_sram_axi #(
        .DEPTH_WORDS(1024),
        .BASE_ADDR  (32'h8000_0000),
        .LATENCY    (LAT),
        .LFSR_SEED  (8'hA5)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .araddr (araddr),
        .arvalid(arvalid),
        .arready(arready),
        .rdata  (rdata),
        .rresp  (rresp),
        .rvalid (rvalid),
        .rready (rready),
        .awaddr (awaddr),
        .awvalid(awvalid),
        .awready(awready),
        .wdata  (wdata),
        .wstrb  (wstrb),
        .wvalid (wvalid),
        .wready (wready),
        .bresp  (bresp),
        .bvalid (bvalid),
        .bready (bready)
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        int          cyc;
    } exp_t;

    exp_t rq[$];
    exp_t bq[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    bit   r_seen     = 0;
    bit   b_seen     = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            r_seen = 0;
        end else begin
            if (rvalid && !r_seen) begin
                r_seen = 1;
                if (rq.size() == 0) check("r_unexpected", 32'(rvalid), 0);
                else                check("r_latency", cyc, rq[0].cyc);
            end else if (!rvalid && r_seen) begin
                check("r_dropped", 32'(rvalid), 1);
                r_seen = 0;
            end
            if (rvalid && rready) begin
                if (rq.size() > 0) begin
                    check("rdata", rdata, rq[0].data);
                    check("rresp", 32'(rresp), 32'(rq[0].resp));
                    void'(rq.pop_front());
                end
                r_seen = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            b_seen = 0;
        end else begin
            if (bvalid && !b_seen) begin
                b_seen = 1;
                if (bq.size() == 0) check("b_unexpected", 32'(bvalid), 0);
                else                check("b_latency", cyc, bq[0].cyc);
            end else if (!bvalid && b_seen) begin
                check("b_dropped", 32'(bvalid), 1);
                b_seen = 0;
            end
            if (bvalid && bready) begin
                if (bq.size() > 0) begin
                    check("bresp", 32'(bresp), 32'(bq[0].resp));
                    void'(bq.pop_front());
                end
                b_seen = 0;
            end
        end
    end

    task automatic send_aw(input logic [31:0] a, input int dly, output int hs);
        bit ok = 0;
        int t = 0;
        if (dly > 0) begin
            repeat (dly) @(posedge clk);
            #1;
        end
        awaddr  = a;
        awvalid = 1'b1;
        while (!ok && t < 50) begin
            @(negedge clk);
            ok = awready;
            @(posedge clk);
            t++;
        end
        #1 awvalid = 1'b0;
        hs = cyc;
        check("aw_accept", 32'(ok), 1);
    endtask

    task automatic send_w(input logic [31:0] d, input logic [7:0] s, input int dly, output int hs);
        bit ok = 0;
        int t = 0;
        if (dly > 0) begin
            repeat (dly) @(posedge clk);
            #1;
        end
        wdata  = d;
        wstrb  = s;
        wvalid = 1'b1;
        while (!ok && t < 50) begin
            @(negedge clk);
            ok = wready;
            @(posedge clk);
            t++;
        end
        #1 wvalid = 1'b0;
        hs = cyc;
        check("w_accept", 32'(ok), 1);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
        bit ok = 0;
        int t = 0;
        araddr  = a;
        arvalid = 1'b1;
        while (!ok && t < 50) begin
            @(negedge clk);
            ok = arready;
            @(posedge clk);
            t++;
        end
        #1 arvalid = 1'b0;
        check("ar_accept", 32'(ok), 1);
        rq.push_back('{data: d, resp: r, cyc: cyc + LAT});
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s,
                            input logic [1:0] r, input int aw_dly, input int w_dly);
        int ha;
        int hw;
        fork
            send_aw(a, aw_dly, ha);
            send_w(d, s, w_dly, hw);
        join
        bq.push_back('{data: 32'h0, resp: r, cyc: ((ha > hw) ? ha : hw) + LAT});
    endtask

    task automatic drain();
        int t = 0;
        while ((rq.size() != 0 || bq.size() != 0) && t < 100) begin
            @(posedge clk);
            t++;
        end
        check("drain_pending", 32'(rq.size() + bq.size()), 0);
        rq.delete();
        bq.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ha;
        int hw;
        rst     = 1'b1;
        araddr  = '0;
        arvalid = 1'b0;
        rready  = 1'b1;
        awaddr  = '0;
        awvalid = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        wvalid  = 1'b0;
        bready  = 1'b1;

        #1 rst = 1'b0;
        #1;
        check("rst_arready", 32'(arready), 1);
        check("rst_awready", 32'(awready), 1);
        check("rst_wready",  32'(wready),  1);
        check("rst_rvalid",  32'(rvalid),  0);
        check("rst_bvalid",  32'(bvalid),  0);
        check("rst_rdata",   rdata,        0);
        check("rst_rresp",   32'(rresp),   0);
        check("rst_bresp",   32'(bresp),   0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // full-word write then read
        do_write(32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 2'b00, 0, 0);
        drain();
        do_read(32'h8000_0010, 32'hDEAD_BEEF, 2'b00);
        drain();

        // single-lane write
        do_write(32'h8000_0010, 32'h0000_5500, 8'h02, 2'b00, 0, 0);
        drain();
        do_read(32'h8000_0010, 32'hDEAD_55EF, 2'b00);
        drain();

        // only upper strobe bits set: no lane enabled
        do_write(32'h8000_0010, 32'hFFFF_FFFF, 8'hF0, 2'b00, 0, 0);
        drain();
        do_read(32'h8000_0013, 32'hDEAD_55EF, 2'b00);
        drain();

        // W leads AW by 3 cycles, B held off by bready
        bready = 1'b0;
        do_write(32'h8000_0020, 32'hCAFE_F00D, 8'h0F, 2'b00, 3, 0);
        repeat (LAT + 3) @(posedge clk);
        #1 bready = 1'b1;
        drain();
        do_read(32'h8000_0020, 32'hCAFE_F00D, 2'b00);
        drain();

        // out-of-range accesses; word 0 must survive an aliasing write
        do_write(32'h8000_0000, 32'hA5A5_0000, 8'h0F, 2'b00, 0, 0);
        drain();
        do_read(32'h7FFF_FFFC, 32'h0, 2'b10);
        drain();
        do_write(32'h8000_1000, 32'h1234_5678, 8'h0F, 2'b10, 0, 0);
        drain();
        do_read(32'h8000_0000, 32'hA5A5_0000, 2'b00);
        drain();
        do_read(32'h8000_0FFC + 32'h4, 32'h0, 2'b10);
        drain();

        // same-edge read and write commit on one word
        do_write(32'h8000_0040, 32'h1111_1111, 8'h0F, 2'b00, 0, 0);
        drain();
        fork
            do_read(32'h8000_0040, 32'h1111_1111, 2'b00);
            do_write(32'h8000_0040, 32'h2222_2222, 8'h0F, 2'b00, 0, 0);
        join
        drain();
        do_read(32'h8000_0040, 32'h2222_2222, 2'b00);
        drain();

        // back-to-back reads
        do_read(32'h8000_0020, 32'hCAFE_F00D, 2'b00);
        do_read(32'h8000_0040, 32'h2222_2222, 2'b00);
        drain();

        // reset pulse while the write waits to commit
        fork
            send_aw(32'h8000_0040, 0, ha);
            send_w(32'h3333_3333, 8'h0F, 0, hw);
        join
        #1 rst = 1'b0;
        #1;
        check("mid_rst_arready", 32'(arready), 1);
        check("mid_rst_awready", 32'(awready), 1);
        check("mid_rst_wready",  32'(wready),  1);
        check("mid_rst_rvalid",  32'(rvalid),  0);
        check("mid_rst_bvalid",  32'(bvalid),  0);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_bvalid", 32'(bvalid), 0);
        do_read(32'h8000_0040, 32'h2222_2222, 2'b00);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
